// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data-memory responder with a byte-addressed
// big-endian RAM and a configurable number of wait states.
// Optional feature macro: DATAMEM_ALIGN_CHECK_EN (flags misaligned word accesses).
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        datamem_en,
    input  logic        readwrite,
    input  logic        size,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        align_err
);

    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    logic [7:0]        mem [DEPTH];
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic              size_q, size_d;
    logic [31:0]       data_out_q, data_out_d;

    logic              enter_done;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_rw;
    logic              acc_size;
    logic              acc_mis;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic              mem_we;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^address[31:ADDR_W];

    // Next-state, request latching and wait-state countdown
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        size_d     = size_q;
        enter_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (datamem_en) begin
                    addr_d  = address[ADDR_W-1:0];
                    wdata_d = data_in;
                    rw_d    = readwrite;
                    size_d  = size;
                    cnt_d   = WS;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access operands: with zero wait states the access happens on the same
    // edge that latches the request, so the live inputs are used directly.
    always_comb begin
        acc_addr  = (state_q == IDLE) ? address[ADDR_W-1:0] : addr_q;
        acc_wdata = (state_q == IDLE) ? data_in : wdata_q;
        acc_rw    = (state_q == IDLE) ? readwrite : rw_q;
        acc_size  = (state_q == IDLE) ? size : size_q;
`ifdef DATAMEM_ALIGN_CHECK_EN
        acc_mis   = acc_size && (acc_addr[1:0] != 2'b00);
`else
        acc_mis   = 1'b0;
`endif
        a0        = {acc_addr[ADDR_W-1:2], 2'b00};
        a1        = a0 + ADDR_W'(1);
        a2        = a0 + ADDR_W'(2);
        a3        = a0 + ADDR_W'(3);
        mem_we    = enter_done && acc_rw && !acc_mis && !reset;
        data_out_d = data_out_q;
        if (enter_done && !acc_rw && !acc_mis) begin
            if (acc_size)
                data_out_d = {mem[a0], mem[a1], mem[a2], mem[a3]};
            else
                data_out_d = {24'b0, mem[acc_addr]};
        end
    end

    // Control and load-data registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            rw_q       <= 1'b0;
            size_q     <= 1'b0;
            data_out_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            size_q     <= size_d;
            data_out_q <= data_out_d;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (acc_size) begin
                mem[a0] <= acc_wdata[31:24];
                mem[a1] <= acc_wdata[23:16];
                mem[a2] <= acc_wdata[15:8];
                mem[a3] <= acc_wdata[7:0];
            end else begin
                mem[acc_addr] <= acc_wdata[7:0];
            end
        end
    end

    assign data_out = data_out_q;
    assign stall    = datamem_en && (state_q != DONE);
    assign done     = (state_q == DONE);
`ifdef DATAMEM_ALIGN_CHECK_EN
    assign align_err = (state_q == DONE) && size_q && (addr_q[1:0] != 2'b00);
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the MEM stage of the pipelined ARM processor. It accepts the MEM-stage memory control signals (enable, read/write, size) with the effective address and store data. It performs byte or word accesses on a byte-addressed big-endian RAM, inserting a configurable number of wait states. While an access is outstanding it drives `stall` to the hazard unit, and it returns load data on `data_out` for the MEM/WB register.

## Interface
Parameters:
- `ADDR_W`, 8: byte-address width; RAM holds 2^ADDR_W bytes.
- `WAIT_STATES`, 1: extra cycles inserted before an access completes (0–15).

Ports:
- `clk`  input  1  single clock, rising-edge.
- `reset`  input  1  asynchronous, active-high reset.
- `datamem_en`  input  1  request valid; held by the pipeline until the access completes.
- `readwrite`  input  1  0 = read (load), 1 = write (store).
- `size`  input  1  0 = byte, 1 = word.
- `address`  input  32  effective address; only `[ADDR_W-1:0]` is used.
- `data_in`  input  32  store data; byte stores use `[7:0]`.
- `data_out`  output  32  registered load data.
- `stall`  output  1  combinational; holds the IF/ID/EXE/MEM registers.
- `done`  output  1  one-cycle pulse when an access completes.
- `align_err`  output  1  one-cycle misaligned-word pulse (see Configuration).

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - If `datamem_en`=0: remain in IDLE.
  - If `datamem_en`=1: latch `address[ADDR_W-1:0]`, `data_in`, `readwrite` and `size`, and load `cnt` with `WAIT_STATES`.
  - Next state is WAIT if `WAIT_STATES`>0, otherwise DONE.
- WAIT:
  - `cnt` decrements each cycle.
  - When `cnt`=1, the next state is DONE. WAIT therefore lasts exactly `WAIT_STATES` cycles.
- On the edge entering DONE, the access is performed using the latched values:
  - Word write: `Mem[A]`=`d[31:24]`, `Mem[A+1]`=`d[23:16]`, `Mem[A+2]`=`d[15:8]`, `Mem[A+3]`=`d[7:0]` (big-endian).
  - Byte write: `Mem[A]`=`d[7:0]`.
  - Word read: `data_out`={`Mem[A]`,`Mem[A+1]`,`Mem[A+2]`,`Mem[A+3]`}.
  - Byte read: `data_out`={24'b0,`Mem[A]`} (zero-extended).
  - Writes leave `data_out` unchanged.
- DONE:
  - `done`=1 for exactly one cycle.
  - Unconditional return to IDLE.
  - A new request is not sampled in DONE; it is sampled in the following IDLE cycle.
- `stall` = `datamem_en` AND (state ≠ DONE).
- Address width: word address A = latched address with `[1:0]` forced to 0 (without the macro). A+3 never exceeds 2^ADDR_W−1, so there is no wrap.
- Reset at any time:
  - Outputs: `data_out`=0, `done`=0, `align_err`=0, `cnt`=0, state IDLE.
  - An in-flight write is not committed.
  - RAM contents are not cleared.
- `datamem_en` is sampled only in IDLE. Changes during WAIT are ignored; the latched request completes.

## Timing
- Request first asserted in cycle 0 (state IDLE): `stall` is high in cycles 0..`WAIT_STATES`, and `done` is high in cycle `WAIT_STATES`+1.
- Load data is valid on `data_out` from cycle `WAIT_STATES`+1 and holds until the next completed read or reset.
- The pipeline advances on the edge ending the DONE cycle.
- Back-to-back requests: the next request is sampled in the cycle after DONE, giving a minimum period of `WAIT_STATES`+2 cycles.
- `stall` is combinational from `datamem_en` and state, with no register delay.

## Configuration
- `DATAMEM_ALIGN_CHECK_EN` defined:
  - A word request with `address[1:0]`≠0 still goes through IDLE/WAIT/DONE with normal timing.
  - In DONE, `align_err`=1 for one cycle.
  - The write is suppressed and `data_out` is unchanged.
  - Byte accesses are never flagged.
- `DATAMEM_ALIGN_CHECK_EN` not defined:
  - `align_err` is tied to 0.
  - Word addresses have `[1:0]` forced to 0 and the access proceeds.

## Test plan
- Word store then load, `WAIT_STATES`=1:
  - Store 0xDEADBEEF to address 0x10; load word from 0x10 → `data_out`=0xDEADBEEF.
  - Byte load from 0x10 → 0x000000DE; byte load from 0x13 → 0x000000EF.
- Byte store 0x5A to 0x21 over existing word 0x11223344 at 0x20 → word load at 0x20 returns 0x115A3344.
- Wait-state timing:
  - `WAIT_STATES`=3, read request held high → `stall` high for exactly 4 cycles, `done` pulses in cycle 4.
  - `WAIT_STATES`=0 → `stall` high for 1 cycle, `done` in cycle 1.
- Reset during WAIT of a word store of 0xCAFEF00D to 0x40 (prior content 0):
  - `stall`/`done` drop immediately; `data_out`=0.
  - A subsequent load from 0x40 returns 0x00000000.
- Misaligned word store of 0x12345678 to 0x42:
  - Macro defined → `align_err` pulse in DONE; RAM at 0x40 unchanged.
  - Macro undefined → a word load from 0x40 returns 0x12345678.
- `datamem_en`=0 with `readwrite`=1 for 10 cycles → `stall`=0, `done`=0, RAM unchanged.
